// File: rtl/obj_dma.sv
// obj_dma: on VB rising edge or DMA_GO, copies N_OBJ*OBJ_BYTES bytes from the CPU bus
// into the back half of a double-buffered object table, swapping halves only on completion.
module obj_dma #(
    parameter int AW          = 12,
    parameter int DW          = 8,
    parameter int N_OBJ       = 64,
    parameter int OBJ_BYTES   = 4,
    parameter int RD_LAT      = 1,
    parameter int AUTO        = 1,
    parameter int ABORT_ON_VB = 1
) (
    input  logic                          CLK20,
    input  logic                          RESET,
    input  logic                          VB,
    input  logic                          DMA_GO,
    input  logic [AW-1:0]                 SRC_BASE,
    output logic                          BUSRQn,
    input  logic                          BUSAK_n,
    output logic [AW-1:0]                 AD,
    output logic                          MEMRD,
    input  logic [DW-1:0]                 DD,
    output logic                          DMCS,
    output logic                          DONE,
    output logic                          ABORT,
    output logic                          BANK,
    input  logic [$clog2(N_OBJ)-1:0]      OBJ_IDX,
    output logic [OBJ_BYTES*DW-1:0]       OBJ_DATA
);
    localparam int EW = $clog2(N_OBJ);
    localparam int LW = (OBJ_BYTES > 1) ? $clog2(OBJ_BYTES) : 1;
    localparam int OW = OBJ_BYTES * DW;
    localparam logic [EW-1:0] LAST_ENT  = EW'(N_OBJ - 1);
    localparam logic [LW-1:0] LAST_LANE = LW'(OBJ_BYTES - 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_XFER, S_DRAIN, S_REL} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   base_q, base_d, ad_q, ad_d;
    logic [EW-1:0]   ent_q, ent_d;
    logic [LW-1:0]   lane_q, lane_d;
    logic            vbst_q, vbst_d, vb_q;
    logic            busrq_n_q, busrq_n_d, memrd_q, memrd_d, dmcs_q, dmcs_d;
    logic            done_q, done_d, abort_q, abort_d, bank_q, bank_d;
    logic [OW-1:0]   obj_data_q, obj_data_d;
    logic [RD_LAT-1:0] pv_q;
    logic [EW-1:0]   pe_q [RD_LAT];
    logic [LW-1:0]   pl_q [RD_LAT];
    logic [OW-1:0]   table_mem [2*N_OBJ];

    logic            trig_s, vb_edge_s, abort_s, last_issue_s, cap_v_s, cap_last_s;
    logic [EW-1:0]   cap_e_s;
    logic [LW-1:0]   cap_l_s;

    assign vb_edge_s    = (AUTO != 0) && VB && !vb_q;
    assign trig_s       = DMA_GO || vb_edge_s;
    assign abort_s      = (ABORT_ON_VB != 0) && vbst_q && !VB;
    assign last_issue_s = (ent_q == LAST_ENT) && (lane_q == LAST_LANE);
    // The tail of the read-latency pipe names the byte whose DD is valid this cycle.
    assign cap_e_s      = pe_q[RD_LAT-1];
    assign cap_l_s      = pl_q[RD_LAT-1];
    assign cap_v_s      = pv_q[RD_LAT-1] && (state_q == S_XFER || state_q == S_DRAIN);
    assign cap_last_s   = cap_v_s && (cap_e_s == LAST_ENT) && (cap_l_s == LAST_LANE);

    // Next-state and registered-output decode.
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        ad_d     = ad_q;
        ent_d    = ent_q;
        lane_d   = lane_q;
        vbst_d   = vbst_q;
        bank_d   = bank_q;
        memrd_d  = 1'b0;
        done_d   = 1'b0;
        abort_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (trig_s) begin
                    base_d  = SRC_BASE;
                    ent_d   = '0;
                    lane_d  = '0;
                    vbst_d  = vb_edge_s;
                    state_d = S_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (abort_s) begin
                    abort_d = 1'b1;
                    state_d = S_REL;
                end else if (!BUSAK_n) begin
                    memrd_d = 1'b1;
                    ad_d    = base_q;
                    state_d = S_XFER;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_XFER: begin
                if (abort_s) begin
                    abort_d = 1'b1;
                    state_d = S_REL;
                end else begin
                    if (lane_q == LAST_LANE) begin
                        lane_d = '0;
                        ent_d  = ent_q + EW'(1);
                    end else begin
                        lane_d = lane_q + LW'(1);
                    end
                    if (last_issue_s) begin
                        state_d = S_DRAIN;
                    end else begin
                        memrd_d = 1'b1;
                        ad_d    = ad_q + AW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (abort_s) begin
                    abort_d = 1'b1;
                    state_d = S_REL;
                end else if (cap_last_s) begin
                    done_d  = 1'b1;
                    bank_d  = ~bank_q;
                    state_d = S_REL;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_REL: begin
                if (BUSAK_n) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_REL;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busrq_n_d  = !(state_d inside {S_REQ, S_XFER, S_DRAIN});
        dmcs_d     = state_d inside {S_XFER, S_DRAIN};
        obj_data_d = table_mem[{bank_q, OBJ_IDX}];
    end

    // Control and output registers.
    always_ff @(posedge CLK20) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            ad_q       <= '0;
            ent_q      <= '0;
            lane_q     <= '0;
            vbst_q     <= 1'b0;
            vb_q       <= 1'b0;
            busrq_n_q  <= 1'b1;
            memrd_q    <= 1'b0;
            dmcs_q     <= 1'b0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
            bank_q     <= 1'b0;
            obj_data_q <= '0;
            pv_q       <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            ad_q       <= ad_d;
            ent_q      <= ent_d;
            lane_q     <= lane_d;
            vbst_q     <= vbst_d;
            vb_q       <= VB;
            busrq_n_q  <= busrq_n_d;
            memrd_q    <= memrd_d;
            dmcs_q     <= dmcs_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
            bank_q     <= bank_d;
            obj_data_q <= obj_data_d;
            pv_q[0]    <= memrd_q;
            for (int i = 1; i < RD_LAT; i++) pv_q[i] <= pv_q[i-1];
        end
    end

    // Byte-index pipe matching the bus read latency.
    always_ff @(posedge CLK20) begin
        pe_q[0] <= ent_q;
        pl_q[0] <= lane_q;
        for (int i = 1; i < RD_LAT; i++) begin
            pe_q[i] <= pe_q[i-1];
            pl_q[i] <= pl_q[i-1];
        end
    end

    // Back-half capture; the front half (index bank_q) is never written.
    always_ff @(posedge CLK20) begin
        if (cap_v_s) begin
            table_mem[{~bank_q, cap_e_s}][cap_l_s*DW +: DW] <= DD;
        end
    end

    assign BUSRQn   = busrq_n_q;
    assign AD       = ad_q;
    assign MEMRD    = memrd_q;
    assign DMCS     = dmcs_q;
    assign DONE     = done_q;
    assign ABORT    = abort_q;
    assign BANK     = bank_q;
    assign OBJ_DATA = obj_data_q;
endmodule

// File: tb/tb_obj_dma.sv
// Bench for obj_dma: a default-parameter instance and a small RD_LAT=3 instance,
// each with a byte[a]=a[7:0] memory model and an address scoreboard.
module tb_obj_dma;
    logic clk;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    // default instance
    logic        rst1, vb1, go1, busak1_n, busrq1_n, memrd1, dmcs1, done1, abort1, bank1;
    logic [11:0] base1, ad1, h1;
    logic [7:0]  dd1;
    logic [5:0]  idx1;
    logic [31:0] data1;
    // small instance
    logic        rst2, vb2, go2, busak2_n, busrq2_n, memrd2, dmcs2, done2, abort2, bank2;
    logic [11:0] base2, ad2;
    logic [11:0] h2 [3];
    logic [7:0]  dd2;
    logic [2:0]  idx2;
    logic [15:0] data2;

    obj_dma dut1 (
        .CLK20(clk), .RESET(rst1), .VB(vb1), .DMA_GO(go1), .SRC_BASE(base1),
        .BUSRQn(busrq1_n), .BUSAK_n(busak1_n), .AD(ad1), .MEMRD(memrd1), .DD(dd1),
        .DMCS(dmcs1), .DONE(done1), .ABORT(abort1), .BANK(bank1),
        .OBJ_IDX(idx1), .OBJ_DATA(data1)
    );

    obj_dma #(.N_OBJ(8), .OBJ_BYTES(2), .RD_LAT(3)) dut2 (
        .CLK20(clk), .RESET(rst2), .VB(vb2), .DMA_GO(go2), .SRC_BASE(base2),
        .BUSRQn(busrq2_n), .BUSAK_n(busak2_n), .AD(ad2), .MEMRD(memrd2), .DD(dd2),
        .DMCS(dmcs2), .DONE(done2), .ABORT(abort2), .BANK(bank2),
        .OBJ_IDX(idx2), .OBJ_DATA(data2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // memory model: data for an address appears RD_LAT cycles after issue
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        h1    <= ad1;
        h2[0] <= ad2;
        h2[1] <= h2[0];
        h2[2] <= h2[1];
    end
    assign dd1 = h1[7:0];
    assign dd2 = h2[2][7:0];

    // scoreboards: expected addresses queued at trigger time, consumed per MEMRD
    logic [11:0] q1 [$];
    logic [11:0] q2 [$];
    int rd1_cnt = 0, done1_cnt = 0, abort1_cnt = 0, last_rd1 = 0, sb1_err = 0;
    int rd2_cnt = 0, done2_cnt = 0, abort2_cnt = 0, last_rd2 = 0, sb2_err = 0;
    logic [11:0] last_ad1 = 12'h000;

    always @(negedge clk) begin
        if (memrd1 === 1'b1) begin
            rd1_cnt  <= rd1_cnt + 1;
            last_rd1 <= cyc;
            last_ad1 <= ad1;
            if (q1.size() == 0) begin
                sb1_err <= sb1_err + 1;
                $display("FAIL sb1_ad: got 0x%0h, none expected", ad1);
            end else begin
                if (ad1 !== q1[0]) begin
                    sb1_err <= sb1_err + 1;
                    $display("FAIL sb1_ad: got 0x%0h expected 0x%0h", ad1, q1[0]);
                end
                void'(q1.pop_front());
            end
        end
        if (done1 === 1'b1) done1_cnt <= done1_cnt + 1;
        if (abort1 === 1'b1) abort1_cnt <= abort1_cnt + 1;
    end

    always @(negedge clk) begin
        if (memrd2 === 1'b1) begin
            rd2_cnt  <= rd2_cnt + 1;
            last_rd2 <= cyc;
            if (q2.size() == 0) begin
                sb2_err <= sb2_err + 1;
                $display("FAIL sb2_ad: got 0x%0h, none expected", ad2);
            end else begin
                if (ad2 !== q2[0]) begin
                    sb2_err <= sb2_err + 1;
                    $display("FAIL sb2_ad: got 0x%0h expected 0x%0h", ad2, q2[0]);
                end
                void'(q2.pop_front());
            end
        end
        if (done2 === 1'b1) done2_cnt <= done2_cnt + 1;
        if (abort2 === 1'b1) abort2_cnt <= abort2_cnt + 1;
    end

    typedef struct {
        int          phase;
        logic [5:0]  idx;
        logic [31:0] data;
    } rb_t;
    rb_t rb [16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_done(input int which, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if ((which == 1 ? done1 : done2) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic readback(input int phase);
        for (int i = 0; i < 16; i++) begin
            if (rb[i].phase == phase) begin
                idx1 = rb[i].idx;
                idx2 = rb[i].idx[2:0];
                tick();
                if (phase >= 10) check($sformatf("rb%0d_idx%0d", phase, rb[i].idx), 64'(data2), 64'(rb[i].data));
                else             check($sformatf("rb%0d_idx%0d", phase, rb[i].idx), 64'(data1), 64'(rb[i].data));
            end
        end
    endtask

    bit ok;
    int r0, d0, a0;

    initial begin
        rb[0]  = '{1, 6'd3,  32'h0F0E0D0C};
        rb[1]  = '{1, 6'd0,  32'h03020100};
        rb[2]  = '{1, 6'd63, 32'hFFFEFDFC};
        rb[3]  = '{1, 6'd32, 32'h83828180};
        rb[4]  = '{2, 6'd32, 32'h03020100};
        rb[5]  = '{2, 6'd0,  32'h83828180};
        rb[6]  = '{2, 6'd31, 32'hFFFEFDFC};
        rb[7]  = '{2, 6'd63, 32'h7F7E7D7C};
        rb[8]  = '{3, 6'd32, 32'h03020100};
        rb[9]  = '{3, 6'd1,  32'h87868584};
        rb[10] = '{4, 6'd0,  32'hC3C2C1C0};
        rb[11] = '{4, 6'd63, 32'hBFBEBDBC};
        rb[12] = '{4, 6'd16, 32'h03020100};
        rb[13] = '{10, 6'd0, 32'h00004140};
        rb[14] = '{10, 6'd5, 32'h00004B4A};
        rb[15] = '{10, 6'd7, 32'h00004F4E};

        rst1 = 1'b1; vb1 = 1'b0; go1 = 1'b0; busak1_n = 1'b1; base1 = 12'h000; idx1 = 6'd0;
        rst2 = 1'b1; vb2 = 1'b0; go2 = 1'b0; busak2_n = 1'b1; base2 = 12'h000; idx2 = 3'd0;
        repeat (3) tick();
        check("rst_busrq", 64'(busrq1_n), 64'(1'b1));
        check("rst_memrd", 64'(memrd1), 64'(1'b0));
        check("rst_ad", 64'(ad1), 64'(12'h000));
        check("rst_dmcs_done_abort", 64'({dmcs1, done1, abort1}), 64'(3'b000));
        check("rst_bank", 64'(bank1), 64'(1'b0));
        check("rst_objdata", 64'(data1), 64'(32'h0));
        rst1 = 1'b0; rst2 = 1'b0;
        tick();

        // T1: VB rise, base 0x100
        base1 = 12'h100;
        for (int k = 0; k < 256; k++) q1.push_back(12'(12'h100 + k));
        r0 = rd1_cnt; d0 = done1_cnt;
        vb1 = 1'b1;
        tick();
        check("t1_req", 64'(busrq1_n), 64'(1'b0));
        tick();
        busak1_n = 1'b0;
        tick();
        check("t1_first_rd", 64'({memrd1, dmcs1, ad1}), 64'({1'b1, 1'b1, 12'h100}));
        wait_done(1, 400, ok);
        check("t1_done_seen", 64'(ok), 64'(1'b1));
        check("t1_done_lat", 64'(cyc - last_rd1), 64'(2));
        check("t1_release", 64'({busrq1_n, dmcs1, bank1}), 64'(3'b101));
        tick();
        check("t1_done_pulse", 64'(done1), 64'(1'b0));
        busak1_n = 1'b1; vb1 = 1'b0;
        repeat (2) tick();
        check("t1_reads", 64'(rd1_cnt - r0), 64'(256));
        check("t1_dones", 64'(done1_cnt - d0), 64'(1));
        readback(1);

        // T2: wrap from 0xF80
        base1 = 12'hF80;
        for (int k = 0; k < 256; k++) q1.push_back(12'(12'hF80 + k));
        vb1 = 1'b1;
        repeat (2) tick();
        busak1_n = 1'b0;
        wait_done(1, 400, ok);
        check("t2_done_seen", 64'(ok), 64'(1'b1));
        check("t2_last_ad", 64'(last_ad1), 64'(12'h07F));
        check("t2_bank", 64'(bank1), 64'(1'b0));
        tick();
        busak1_n = 1'b1; vb1 = 1'b0;
        repeat (2) tick();
        readback(2);

        // T3: VB falls while read k=100 is issued
        base1 = 12'h100;
        for (int k = 0; k <= 100; k++) q1.push_back(12'(12'h100 + k));
        r0 = rd1_cnt; d0 = done1_cnt; a0 = abort1_cnt;
        vb1 = 1'b1;
        repeat (2) tick();
        busak1_n = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (memrd1 === 1'b1 && ad1 == 12'h164) begin
                vb1 = 1'b0;
                ok = 1'b1;
                break;
            end
        end
        check("t3_k100_seen", 64'(ok), 64'(1'b1));
        tick();
        check("t3_abort", 64'({abort1, busrq1_n, memrd1, dmcs1, bank1}), 64'(5'b11000));
        tick();
        check("t3_abort_pulse", 64'(abort1), 64'(1'b0));
        busak1_n = 1'b1;
        repeat (3) tick();
        check("t3_reads", 64'(rd1_cnt - r0), 64'(101));
        check("t3_no_done", 64'(done1_cnt - d0), 64'(0));
        check("t3_aborts", 64'(abort1_cnt - a0), 64'(1));
        check("t3_sb_empty", 64'(q1.size()), 64'(0));
        readback(3);

        // T6: VB edge and DMA_GO together
        base1 = 12'h3C0;
        for (int k = 0; k < 256; k++) q1.push_back(12'(12'h3C0 + k));
        r0 = rd1_cnt; d0 = done1_cnt;
        go1 = 1'b1; vb1 = 1'b1;
        tick();
        go1 = 1'b0;
        check("t6_req", 64'(busrq1_n), 64'(1'b0));
        busak1_n = 1'b0;
        wait_done(1, 400, ok);
        check("t6_done_seen", 64'(ok), 64'(1'b1));
        tick();
        busak1_n = 1'b1;
        repeat (20) tick();
        check("t6_reads", 64'(rd1_cnt - r0), 64'(256));
        check("t6_dones", 64'(done1_cnt - d0), 64'(1));
        check("t6_idle", 64'({busrq1_n, bank1}), 64'(2'b11));
        readback(4);
        vb1 = 1'b0;

        // T4: small instance, DMA_GO with VB low, second GO during XFER
        base2 = 12'h240;
        for (int k = 0; k < 16; k++) q2.push_back(12'(12'h240 + k));
        r0 = rd2_cnt; d0 = done2_cnt;
        go2 = 1'b1;
        tick();
        go2 = 1'b0;
        check("t4_req", 64'(busrq2_n), 64'(1'b0));
        busak2_n = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (memrd2 === 1'b1 && ad2 == 12'h245) begin
                check("t4_dmcs", 64'(dmcs2), 64'(1'b1));
                go2 = 1'b1;
                tick();
                go2 = 1'b0;
                ok = 1'b1;
                break;
            end
        end
        check("t4_mid_seen", 64'(ok), 64'(1'b1));
        wait_done(2, 100, ok);
        check("t4_done_seen", 64'(ok), 64'(1'b1));
        check("t4_done_lat", 64'(cyc - last_rd2), 64'(4));
        check("t4_bank", 64'(bank2), 64'(1'b1));
        tick();
        busak2_n = 1'b1;
        repeat (20) tick();
        check("t4_reads", 64'(rd2_cnt - r0), 64'(16));
        check("t4_dones", 64'(done2_cnt - d0), 64'(1));
        check("t4_idle", 64'(busrq2_n), 64'(1'b1));
        readback(10);

        // T5: RESET during XFER
        base2 = 12'h500;
        for (int k = 0; k < 5; k++) q2.push_back(12'(12'h500 + k));
        r0 = rd2_cnt; d0 = done2_cnt;
        go2 = 1'b1;
        tick();
        go2 = 1'b0;
        busak2_n = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (memrd2 === 1'b1 && ad2 == 12'h504) begin
                rst2 = 1'b1;
                ok = 1'b1;
                break;
            end
        end
        check("t5_k4_seen", 64'(ok), 64'(1'b1));
        tick();
        rst2 = 1'b0;
        check("t5_reset", 64'({busrq2_n, memrd2, dmcs2, bank2}), 64'(4'b1000));
        busak2_n = 1'b1;
        repeat (10) tick();
        check("t5_no_done", 64'(done2_cnt - d0), 64'(0));
        check("t5_reads", 64'(rd2_cnt - r0), 64'(5));

        check("sb1_errors", 64'(sb1_err), 64'(0));
        check("sb2_errors", 64'(sb2_err), 64'(0));
        check("sb2_empty", 64'(q2.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/obj_dma.md
# obj_dma

Parametrised object-table DMA engine for the video subsystem. On vertical blank, or on a CPU strobe, it requests the CPU bus and copies N_OBJ × OBJ_BYTES bytes from CPU memory into the back half of an internal double-buffered object table. It swaps halves only after a complete transfer, so the sprite engine always reads a coherent front table. It replaces the fixed-size, single-buffer object DMA: table size, bus widths and read latency are parameters, and the block adds CPU-triggered transfers, abort on blank end, and tear-free buffer swap.

## Interface
Parameters:
- AW, 12, CPU address width
- DW, 8, CPU data width
- N_OBJ, 64, objects per table (power of two, ≥2)
- OBJ_BYTES, 4, bytes per object (1..8)
- RD_LAT, 1, cycles from MEMRD/AD issue to valid DD (1..3)
- AUTO, 1, start a transfer on VB rising edge when set
- ABORT_ON_VB, 1, abort a transfer when VB falls before it completes

Ports:
- CLK20  in  1  system clock; all logic on its rising edge
- RESET  in  1  synchronous, active-high reset
- VB  in  1  vertical blank; synchronous to CLK20
- DMA_GO  in  1  single-cycle CPU trigger; honoured in IDLE only
- SRC_BASE  in  AW  source start address; latched at trigger
- BUSRQn  out  1  bus request, active low
- BUSAK_n  in  1  bus acknowledge, active low
- AD  out  AW  source address
- MEMRD  out  1  read strobe, one byte per asserted cycle
- DD  in  DW  read data, sampled RD_LAT cycles after issue
- DMCS  out  1  high while the block owns the bus (XFER and DRAIN)
- DONE  out  1  one-cycle pulse on successful completion and swap
- ABORT  out  1  one-cycle pulse when a transfer is abandoned
- BANK  out  1  index of the current front half
- OBJ_IDX  in  log2(N_OBJ)  sprite-engine read index
- OBJ_DATA  out  OBJ_BYTES*DW  front-half entry, registered

## Operation
- States: IDLE, REQ, XFER, DRAIN, REL.
- IDLE:
  - The trigger is DMA_GO, or (AUTO and VB=1 with VB registered 0 the previous cycle).
  - On trigger: latch SRC_BASE, clear the byte counter, go to REQ.
- REQ: BUSRQn=0. The first cycle BUSAK_n=0 is sampled, go to XFER.
- XFER:
  - Each cycle: MEMRD=1, AD=base+k, where k counts 0..N_OBJ*OBJ_BYTES-1.
  - Addition is modulo 2^AW; addresses wrap past the top.
  - After issuing the last k, go to DRAIN.
- Capture (in XFER and DRAIN): the DD sample for byte k is written to the back half at entry k/OBJ_BYTES, bits [(k%OBJ_BYTES)*DW +: DW].
- DRAIN: MEMRD=0; lasts until the final byte is captured.
- Completion, on the cycle after the final capture:
  - BANK toggles, DONE=1 for one cycle, BUSRQn=1, DMCS=0.
  - Go to REL.
- REL: wait for BUSAK_n=1, then go to IDLE.
- Abort:
  - Condition: ABORT_ON_VB is set, the transfer was started by VB, and VB=0 in REQ, XFER or DRAIN.
  - Action on the next cycle: MEMRD=0, BUSRQn=1, ABORT pulses, BANK unchanged, go to REL.
  - The back half contents are then don't-care.
- Triggers arriving outside IDLE are dropped. Triggers are not queued.
- If DMA_GO and a VB edge occur in the same cycle, the transfer starts once and is flagged as VB-started.
- OBJ_DATA = front[OBJ_IDX] with 1-cycle latency. The front half is never written.
- Reset values:
  - State IDLE, BUSRQn=1, MEMRD=0, AD=0, DMCS=0, DONE=0, ABORT=0, BANK=0, OBJ_DATA=0.
  - Table RAM is not cleared.
- RESET mid-transfer: the bus is released on the next cycle, BANK is forced to 0, no DONE pulse.

## Timing
- Trigger sampled in cycle t → BUSRQn low at t+1.
- BUSAK_n low sampled at cycle a → first MEMRD/AD at a+1.
- Last issue at cycle a+N where N = N_OBJ*OBJ_BYTES.
- Final capture at a+N+RD_LAT.
- BANK toggle, DONE and BUSRQn=1 at a+N+RD_LAT+1.
- Defaults: 256 read cycles + 2. Total bus hold = N+RD_LAT+1 cycles after acknowledge.
- A BANK change is visible to an OBJ_DATA read issued in the same cycle on the following cycle's output.
- BUSAK_n rising during XFER is a protocol violation by the bus arbiter; behaviour is undefined and the bench must not exercise it.

## Test plan
- Defaults, memory model byte[a]=a[7:0], SRC_BASE=0x100, VB rise, BUSAK_n 2 cycles after request → 256 MEMRD, AD 0x100..0x1FF; DONE; BANK=1; OBJ_IDX=3 gives OBJ_DATA=0x0F0E0D0C.
- SRC_BASE=0xF80 → AD wraps 0xFFF→0x000 and stops at 0x07F; entry 32 holds bytes from 0x000..0x003.
- VB falls at read k=100 → ABORT pulse, BANK unchanged, previous front data intact, BUSRQn=1 the next cycle.
- DMA_GO with VB low, RD_LAT=3, N_OBJ=8, OBJ_BYTES=2 → 16 reads; DONE 4 cycles after the last issue; a second DMA_GO during XFER is ignored.
- RESET asserted in XFER → BUSRQn=1, MEMRD=0, BANK=0 on the next cycle; no DONE pulse.
- VB edge and DMA_GO in the same cycle → exactly one transfer and one DONE.
